// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART arbitration/dispatch blocks.
// FSM state encoding and the default packet terminator byte.
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_GUARD,
      ARB_DRAIN,
      ARB_LWAIT
   } arb_state_t;

   localparam logic [7:0] PKT_END_DFLT = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr2.sv
// Two-way round-robin pick: on contention the pointer decides,
// otherwise the single requester wins.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      if (&req) begin
         grant = rr_ptr;
      end else begin
         grant = req[1];
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two FWFT byte queues with
// round-robin arbitration and optional per-requester packet lock.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter logic [1:0]  LOCK_EN      = 2'b10,
   parameter logic [7:0]  PKT_END      = PKT_END_DFLT,
   parameter int unsigned MAX_PKT      = 64,
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic       i_empty_n_0,
   input  logic [7:0] i_data_0,
   output logic       o_pop_0,
   input  logic       i_empty_n_1,
   input  logic [7:0] i_data_1,
   output logic       o_pop_1,
   input  logic       i_tx_busy,
   output logic       o_tx_wr,
   output logic [7:0] o_tx_data,
   output logic       o_grant,
   output logic       o_locked
);

   localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);
   localparam int unsigned IDL_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PKT);
   localparam logic [IDL_W-1:0] IDLE_LAST = IDL_W'(LOCK_TIMEOUT - 1);

   arb_state_t       state_q, state_d;
   logic             grant_q, grant_d;
   logic             rr_q, rr_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [IDL_W-1:0] idle_q, idle_d;
   logic             wr_q, wr_d;
   logic             pop0_q, pop0_d;
   logic             pop1_q, pop1_d;

   logic             pick_grant, pick_valid;
   logic             gnt_req;
   logic [7:0]       head;

   arb_rr2 u_rr2 (
      .req    ({i_empty_n_1, i_empty_n_0}),
      .rr_ptr (rr_q),
      .grant  (pick_grant),
      .valid  (pick_valid)
   );

   assign gnt_req   = grant_q ? i_empty_n_1 : i_empty_n_0;
   assign head      = grant_q ? i_data_1 : i_data_0;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign o_tx_data = head;
   assign o_grant   = grant_q;
   assign o_locked  = locked_q;
   assign o_tx_wr   = wr_q;
   assign o_pop_0   = pop0_q;
   assign o_pop_1   = pop1_q;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      locked_d = locked_q;
      cnt_d    = cnt_q;
      idle_d   = idle_q;
      case (state_q)
         ARB_IDLE: begin
            if (!i_tx_busy && pick_valid) begin
               state_d = ARB_ISSUE;
               grant_d = pick_grant;
            end
         end
         ARB_ISSUE: begin
            cnt_d    = cnt_inc;
            locked_d = LOCK_EN[grant_q] && (head != PKT_END) && (cnt_inc < CNT_MAX);
            state_d  = ARB_GUARD;
         end
         // busy only rises the cycle after the write, so skip one look
         ARB_GUARD: state_d = ARB_DRAIN;
         ARB_DRAIN: begin
            if (!i_tx_busy) begin
               if (locked_q) begin
                  if (gnt_req) begin
                     state_d = ARB_ISSUE;
                  end else begin
                     state_d = ARB_LWAIT;
                     idle_d  = '0;
                  end
               end else begin
                  state_d = ARB_IDLE;
                  cnt_d   = '0;
                  rr_d    = ~grant_q;
               end
            end
         end
         ARB_LWAIT: begin
            if (gnt_req) begin
               state_d = ARB_ISSUE;
               idle_d  = '0;
            end else if (idle_q == IDLE_LAST) begin
               state_d  = ARB_IDLE;
               locked_d = 1'b0;
               cnt_d    = '0;
               rr_d     = ~grant_q;
            end else begin
               idle_d = idle_q + IDL_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // strobes are registered, so they are derived from the next state
      wr_d   = (state_d == ARB_ISSUE);
      pop0_d = wr_d && !grant_d;
      pop1_d = wr_d && grant_d;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ARB_IDLE;
         grant_q  <= 1'b0;
         rr_q     <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
         idle_q   <= '0;
         wr_q     <= 1'b0;
         pop0_q   <= 1'b0;
         pop1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
         idle_q   <= idle_d;
         wr_q     <= wr_d;
         pop0_q   <= pop0_d;
         pop1_q   <= pop1_d;
      end
   end

endmodule
